fetch_predict: RTL
==================

FETCH_PREDICT -- requirements
Module: fetch_predict

Interface
REQ-001 Parameter ADDR_W, default 7: PC/instruction-address width in words.
REQ-002 Parameter DATA_W, default 32: instruction width.
REQ-003 Parameter BTB_DEPTH, default 16, power of two: branch-target-buffer entries.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
  pcWrite  in  1  PC update enable (0 = stall)
  IFIDWrite  in  1  IF/ID register enable
  IFFlush  in  1  replace IF/ID contents with NOP
  PCSrc  in  2  0 = sequential/predicted, 1 = jump, 2 = jr, 3 = reserved (treated as 0)
  jumpAddr  in  ADDR_W  jump target
  jrAddr  in  ADDR_W  register-jump target
  brValid  in  1  conditional branch resolved this cycle
  brPC  in  ADDR_W  PC of the resolved branch
  brTaken  in  1  resolved direction
  brTarget  in  ADDR_W  resolved taken target
  brPredTaken  in  1  prediction carried with that branch
  imemWe  in  1  instruction-memory load strobe
  imemAddr  in  ADDR_W  load address
  imemData  in  DATA_W  load data
  instruction  out  DATA_W  IF/ID instruction
  pcOut  out  ADDR_W  PC of the IF/ID instruction
  predTaken  out  1  IF/ID prediction bit
  mispredict  out  1  combinational: brValid & (brTaken != brPredTaken)

Function
REQ-006 Instruction memory SHALL have 2**ADDR_W words, a combinational read at PC, and a synchronous write when imemWe is high; write and fetch of the same word in one cycle returns the old word.
REQ-007 The next PC SHALL follow this priority: mispredict (brTaken ? brTarget : brPC+1) > !pcWrite (hold) > PCSrc=1 jumpAddr > PCSrc=2 jrAddr > BTB hit with counter >= 2 (stored target) > PC+1.
REQ-008 PC+1 and brPC+1 SHALL wrap modulo 2**ADDR_W (max to 0).
REQ-009 The IF/ID register SHALL load as follows: IFFlush or mispredict: instruction = 0, predTaken = 0, pcOut = 0; else IFIDWrite: imem[PC], PC, lookup prediction; else hold.
REQ-010 Fetch latency SHALL be one cycle from PC to instruction.
REQ-011 The BTB SHALL be direct-mapped, indexed by PC[log2(BTB_DEPTH)-1:0], with per-entry valid, tag (upper PC bits), target and a 2-bit saturating counter.
REQ-012 On brValid & brTaken, the BTB entry for brPC SHALL be written valid with tag and target; its counter SHALL increment, saturating at 3, or be set to 2 if the entry missed.
REQ-013 On brValid & !brTaken, a hit SHALL decrement the counter, saturating at 0; a miss SHALL leave the entry unchanged.
REQ-014 A lookup and update to the same index in one cycle SHALL use the pre-update entry.
REQ-015 Mispredict SHALL override pcWrite=0 and IFIDWrite=0.

Reset
REQ-016 Reset SHALL asynchronously set PC = 0, instruction = 0, pcOut = 0, predTaken = 0, all BTB valid = 0 and all counters = 1.
REQ-017 Reset SHALL NOT clear instruction-memory contents.
REQ-018 Reset asserted mid-stall or mid-mispredict SHALL dominate; the first fetch after release is from address 0.

Structure
REQ-019 Package fetch_pkg SHALL hold the PCSrc encodings, counter constants (strong/weak taken and not-taken) and NOP = 0.
REQ-020 The BTB SHALL be a sub-module named btb, parametrised by ADDR_W and BTB_DEPTH.

Verification
REQ-021 Load imem[0..3] = A, B, C, D; release reset -> instruction = A, B, C, D on cycles 1 to 4, with pcOut = 0, 1, 2, 3.
REQ-022 Hold pcWrite = 0 and IFIDWrite = 0 for 2 cycles at PC = 2 -> instruction held for 2 cycles, then resumes at C.
REQ-023 PCSrc = 1 with jumpAddr = 0x40 -> next instruction = imem[0x40]; PCSrc = 2 with jrAddr = 0x7F, then sequential -> fetch of 0x7F followed by 0x00 (wrap).
REQ-024 Resolve brPC = 5 taken to 0x20 twice, then refetch PC 5 -> predTaken = 1 and the next PC is 0x20 with no bubble.
REQ-025 brValid with brPC = 5, brTaken = 0, brPredTaken = 1 during a stall -> mispredict = 1, IF/ID = NOP, next PC = 6.
REQ-026 Assert reset mid-stream with a trained BTB -> all outputs read 0, then a refetch of PC 5 predicts not-taken.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared encodings for the fetch/predict slice: next-PC source
//               select, 2-bit branch counter states, the NOP word and the
//               saturating counter update helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   // Next-PC source select carried on PCSrc. The reserved code behaves
   // exactly like the sequential/predicted path.
   typedef enum logic [1:0] {
      c_PCSRC_SEQ  = 2'd0,
      c_PCSRC_JUMP = 2'd1,
      c_PCSRC_JR   = 2'd2,
      c_PCSRC_RSVD = 2'd3
   } pcSrcT;

   // Two-bit saturating direction counter states.
   localparam logic [1:0] c_CTR_STRONG_NT = 2'd0;
   localparam logic [1:0] c_CTR_WEAK_NT   = 2'd1;
   localparam logic [1:0] c_CTR_WEAK_T    = 2'd2;
   localparam logic [1:0] c_CTR_STRONG_T  = 2'd3;

   // Instruction word that fills IF/ID on a flush.
   localparam int unsigned c_NOP = 0;

   // Move a counter one step toward the resolved direction, saturating at
   // both ends.
   function automatic logic [1:0] ctrUpdate(input logic [1:0] ctr,
                                            input logic       taken);
      logic [1:0] result;
      result = ctr;
      if (taken) begin
         if (ctr != c_CTR_STRONG_T) begin
            result = ctr + 2'd1;
         end
      end else begin
         if (ctr != c_CTR_STRONG_NT) begin
            result = ctr - 2'd1;
         end
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/btb.sv
`default_nettype none
// ============================================================================
// Module      : btb
// Description : Direct-mapped branch target buffer with a 2-bit saturating
//               counter per entry. Lookup is combinational; updates land on
//               the clock edge, so a same-cycle lookup sees the old entry.
// Ports       : clock, reset      - clock / async active-high reset
//               lookupPc          - PC being fetched
//               lookupTaken       - hit with counter in a taken state
//               lookupTarget      - stored target for lookupPc's index
//               updValid/updTaken - a branch resolved / its direction
//               updPc/updTarget   - resolved branch PC / taken target
// Revision    : 1.0 - initial release
// ============================================================================
module btb
   import fetch_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int BTB_DEPTH = 16
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] lookupPc,
   output logic              lookupTaken,
   output logic [ADDR_W-1:0] lookupTarget,
   input  logic              updValid,
   input  logic              updTaken,
   input  logic [ADDR_W-1:0] updPc,
   input  logic [ADDR_W-1:0] updTarget
);

   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = ADDR_W - IDX_W;

   logic              r_valid  [BTB_DEPTH];
   logic [TAG_W-1:0]  r_tag    [BTB_DEPTH];
   logic [ADDR_W-1:0] r_target [BTB_DEPTH];
   logic [1:0]        r_ctr    [BTB_DEPTH];

   logic [IDX_W-1:0]  w_lkIdx;
   logic [TAG_W-1:0]  w_lkTag;
   logic              w_lkHit;
   logic [IDX_W-1:0]  w_updIdx;
   logic [TAG_W-1:0]  w_updTag;
   logic              w_updHit;

   assign w_lkIdx      = lookupPc[IDX_W-1:0];
   assign w_lkTag      = lookupPc[ADDR_W-1:IDX_W];
   assign w_lkHit      = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
   assign lookupTaken  = w_lkHit && (r_ctr[w_lkIdx] >= c_CTR_WEAK_T);
   assign lookupTarget = r_target[w_lkIdx];

   assign w_updIdx = updPc[IDX_W-1:0];
   assign w_updTag = updPc[ADDR_W-1:IDX_W];
   assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

   // Taken branches allocate (or refresh) their entry; a newly allocated
   // entry starts weakly taken. Not-taken branches only weaken an existing
   // entry for the same PC and never allocate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= c_CTR_WEAK_NT;
         end
      end else if (updValid) begin
         if (updTaken) begin
            r_valid[w_updIdx]  <= 1'b1;
            r_tag[w_updIdx]    <= w_updTag;
            r_target[w_updIdx] <= updTarget;
            r_ctr[w_updIdx]    <= w_updHit ? ctrUpdate(r_ctr[w_updIdx], 1'b1)
                                           : c_CTR_WEAK_T;
         end else if (w_updHit) begin
            r_ctr[w_updIdx] <= ctrUpdate(r_ctr[w_updIdx], 1'b0);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_predict.sv
`default_nettype none
// ============================================================================
// Module      : fetch_predict
// Description : Instruction fetch stage with PC register, loadable
//               instruction memory, IF/ID pipeline register and BTB-based
//               branch prediction with mispredict recovery.
// Ports       : clock, reset            - clock / async active-high reset
//               pcWrite, IFIDWrite      - PC and IF/ID enables (0 = stall)
//               IFFlush                 - squash IF/ID to NOP
//               PCSrc, jumpAddr, jrAddr - explicit redirect select/targets
//               brValid..brPredTaken    - resolved branch feedback
//               imemWe/Addr/Data        - instruction memory load port
//               instruction, pcOut,
//               predTaken               - IF/ID register contents
//               mispredict              - resolved branch disagrees with its
//                                         prediction (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_predict
   import fetch_pkg::*;
#(
   parameter int ADDR_W    = 7,
   parameter int DATA_W    = 32,
   parameter int BTB_DEPTH = 16
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              pcWrite,
   input  logic              IFIDWrite,
   input  logic              IFFlush,
   input  logic [1:0]        PCSrc,
   input  logic [ADDR_W-1:0] jumpAddr,
   input  logic [ADDR_W-1:0] jrAddr,
   input  logic              brValid,
   input  logic [ADDR_W-1:0] brPC,
   input  logic              brTaken,
   input  logic [ADDR_W-1:0] brTarget,
   input  logic              brPredTaken,
   input  logic              imemWe,
   input  logic [ADDR_W-1:0] imemAddr,
   input  logic [DATA_W-1:0] imemData,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] pcOut,
   output logic              predTaken,
   output logic              mispredict
);

   localparam int MEM_DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_imem [MEM_DEPTH];
   logic [ADDR_W-1:0] r_pc;
   logic [DATA_W-1:0] r_instruction;
   logic [ADDR_W-1:0] r_pcOut;
   logic              r_predTaken;

   logic [DATA_W-1:0] w_fetchWord;
   logic [ADDR_W-1:0] w_nextPc;
   logic [ADDR_W-1:0] w_pcInc;
   logic [ADDR_W-1:0] w_brPcInc;
   logic              w_btbTaken;
   logic [ADDR_W-1:0] w_btbTarget;
   logic              w_mispredict;

   // Instruction memory: not reset, so program contents survive a reset.
   // The read is asynchronous, so a same-cycle write is seen only from the
   // next cycle on.
   always_ff @(posedge clock) begin
      if (imemWe) begin
         r_imem[imemAddr] <= imemData;
      end
   end

   assign w_fetchWord = r_imem[r_pc];

   btb #(
      .ADDR_W    (ADDR_W),
      .BTB_DEPTH (BTB_DEPTH)
   ) u_btb (
      .clock        (clock),
      .reset        (reset),
      .lookupPc     (r_pc),
      .lookupTaken  (w_btbTaken),
      .lookupTarget (w_btbTarget),
      .updValid     (brValid),
      .updTaken     (brTaken),
      .updPc        (brPC),
      .updTarget    (brTarget)
   );

   assign w_mispredict = brValid && (brTaken != brPredTaken);

   // Increments rely on natural ADDR_W-bit wraparound.
   assign w_pcInc   = r_pc + ADDR_W'(1);
   assign w_brPcInc = brPC + ADDR_W'(1);

   // Recovery from a mispredict outranks a stall; explicit redirects outrank
   // the BTB; the reserved PCSrc code falls through to sequential.
   always_comb begin
      w_nextPc = w_pcInc;
      if (w_mispredict) begin
         w_nextPc = brTaken ? brTarget : w_brPcInc;
      end else if (!pcWrite) begin
         w_nextPc = r_pc;
      end else if (PCSrc == c_PCSRC_JUMP) begin
         w_nextPc = jumpAddr;
      end else if (PCSrc == c_PCSRC_JR) begin
         w_nextPc = jrAddr;
      end else if (w_btbTaken) begin
         w_nextPc = w_btbTarget;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc <= '0;
      end else begin
         r_pc <= w_nextPc;
      end
   end

   // A mispredict squashes the wrong-path fetch even while IF/ID is stalled.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_instruction <= DATA_W'(c_NOP);
         r_pcOut       <= '0;
         r_predTaken   <= 1'b0;
      end else if (IFFlush || w_mispredict) begin
         r_instruction <= DATA_W'(c_NOP);
         r_pcOut       <= '0;
         r_predTaken   <= 1'b0;
      end else if (IFIDWrite) begin
         r_instruction <= w_fetchWord;
         r_pcOut       <= r_pc;
         r_predTaken   <= w_btbTaken;
      end
   end

   assign instruction = r_instruction;
   assign pcOut       = r_pcOut;
   assign predTaken   = r_predTaken;
   assign mispredict  = w_mispredict;

endmodule
`default_nettype wire
